// File: rtl/crc_stream_pkg.sv
// Shared definitions for the streaming CRC engines: FSM encoding, a bit-reversal
// helper and the generator polynomials most often instantiated.
package crc_stream_pkg;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_OUT = 1'b1
    } crc_state_e;

    localparam int CRC_MAX_BITS = 64;

    localparam logic [7:0]  CRC8_POLY        = 8'h07;
    localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
    localparam logic [31:0] CRC32_POLY       = 32'h04C11DB7;

    // Reverses the low 'width' bits of value; bits at and above 'width' return 0.
    function automatic logic [CRC_MAX_BITS-1:0] crc_rev(
        input logic [CRC_MAX_BITS-1:0] value,
        input int                      width
    );
        logic [CRC_MAX_BITS-1:0] result;
        logic [5:0]              src;
        result = '0;
        for (int i = 0; i < CRC_MAX_BITS; i++) begin
            if (i < width) begin
                src              = 6'(width - 1 - i);
                result[6'(i)]    = value[src];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/crc_stream_step.sv
// Combinational CRC update: applies DATA_W serial shift-register steps to crc_in,
// taking data bits LSB-first when REFIN is set and MSB-first otherwise.
module crc_stream_step #(
    parameter int              BITS   = 8,
    parameter logic [BITS-1:0] POLY   = BITS'(7),
    parameter int              DATA_W = 8,
    parameter bit              REFIN  = 1'b0
) (
    input  logic [BITS-1:0]   crc_in,
    input  logic [DATA_W-1:0] data,
    output logic [BITS-1:0]   crc_out
);

    for (genvar i = 0; i < DATA_W; i++) begin : g_step
        localparam int BIDX = REFIN ? i : (DATA_W - 1 - i);

        logic [BITS-1:0] c_in;
        logic [BITS-1:0] c_out;
        logic [BITS-1:0] shifted;
        logic            sel;

        if (i == 0) begin : g_first
            assign c_in = crc_in;
        end else begin : g_next
            assign c_in = g_step[i-1].c_out;
        end

        // A one-bit register has nothing left after the shift.
        if (BITS == 1) begin : g_narrow
            assign shifted = '0;
        end else begin : g_wide
            assign shifted = {c_in[BITS-2:0], 1'b0};
        end

        assign sel   = c_in[BITS-1] ^ data[BIDX];
        assign c_out = shifted ^ (sel ? POLY : '0);
    end

    assign crc_out = g_step[DATA_W-1].c_out;

endmodule

// File: rtl/crc_stream.sv
// Streaming CRC engine: absorbs DATA_W-bit beats over a valid/ready input and
// presents one framed result (CRC plus residue match) per i_last beat.
module crc_stream
    import crc_stream_pkg::*;
#(
    parameter int          BITS    = 8,
    parameter logic [63:0] POLY    = 64'(CRC8_POLY),
    parameter logic [63:0] INIT    = 64'h0,
    parameter int          DATA_W  = 8,
    parameter bit          REFIN   = 1'b0,
    parameter bit          REFOUT  = 1'b0,
    parameter logic [63:0] XOROUT  = 64'h0,
    parameter logic [63:0] RESIDUE = 64'h0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [BITS-1:0]   o_crc,
    output logic              o_match
);

    localparam logic [BITS-1:0] POLY_T    = POLY[BITS-1:0];
    localparam logic [BITS-1:0] INIT_T    = INIT[BITS-1:0];
    localparam logic [BITS-1:0] XOROUT_T  = XOROUT[BITS-1:0];
    localparam logic [BITS-1:0] RESIDUE_T = RESIDUE[BITS-1:0];

    crc_state_e      state_q, state_d;
    logic [BITS-1:0] crc_q, crc_d;
    logic [BITS-1:0] res_crc_q, res_crc_d;
    logic            res_match_q, res_match_d;

    logic [BITS-1:0] crc_step;
    logic [BITS-1:0] crc_rev_t;
    logic [BITS-1:0] crc_final;

    crc_stream_step #(
        .BITS   (BITS),
        .POLY   (POLY_T),
        .DATA_W (DATA_W),
        .REFIN  (REFIN)
    ) u_step (
        .crc_in  (crc_q),
        .data    (i_data),
        .crc_out (crc_step)
    );

    assign crc_rev_t = BITS'(crc_rev(64'(crc_step), BITS));
    assign crc_final = (REFOUT ? crc_rev_t : crc_step) ^ XOROUT_T;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        crc_d       = crc_q;
        res_crc_d   = res_crc_q;
        res_match_d = res_match_q;

        if (i_clr) begin
            state_d = ST_RUN;
            crc_d   = INIT_T;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (i_valid) begin
                        crc_d = crc_step;
                        if (i_last) begin
                            state_d     = ST_OUT;
                            res_crc_d   = crc_final;
                            res_match_d = (crc_step == RESIDUE_T);
                        end
                    end
                end
                ST_OUT: begin
                    if (i_ready) begin
                        state_d = ST_RUN;
                        crc_d   = INIT_T;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // NOTE: state updates use non-blocking assignments so every register samples the pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_RUN;
            crc_q       <= INIT_T;
            res_crc_q   <= '0;
            res_match_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            res_crc_q   <= res_crc_d;
            res_match_q <= res_match_d;
        end
    end

    assign o_ready = (state_q == ST_RUN);
    assign o_valid = (state_q == ST_OUT);
    assign o_crc   = res_crc_q;
    assign o_match = res_match_q;

endmodule

// File: tb/tb_crc_stream.sv
// Self-checking bench for crc_stream: known check values, residue matching,
// backpressure, clear/reset corner cases and random frames against a
// polynomial-division reference model.
module tb_crc_stream;

    typedef struct {
        int          bits;
        logic [63:0] poly;
        logic [63:0] init;
        int          data_w;
        bit          refin;
        bit          refout;
        logic [63:0] xorout;
        logic [63:0] residue;
    } cfg_t;

    typedef struct {
        int          inst;
        string       msg;
        int          extra;
        logic [63:0] exp_crc;
        bit          exp_match;
    } vec_t;

    typedef logic [63:0] beat_q_t[$];

    logic        clk = 1'b0;
    logic        rst, clr, vld, lst, rdy;
    int          sel;
    logic [63:0] d;

    logic [4:0]  v_i, rdy_o, val_o, mat_o;
    logic [63:0] crc_o [5];

    logic [7:0]  crc8;
    logic [15:0] crc16;
    logic [31:0] crc32a, crc32b;
    logic [4:0]  crc5;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 5; k++) begin : g_v
        assign v_i[k] = vld && (sel == k);
    end

    assign crc_o[0] = 64'(crc8);
    assign crc_o[1] = 64'(crc16);
    assign crc_o[2] = 64'(crc32a);
    assign crc_o[3] = 64'(crc32b);
    assign crc_o[4] = 64'(crc5);

    crc_stream #(.BITS(8), .POLY(64'h07), .INIT(64'h0), .DATA_W(8), .REFIN(1'b0),
                 .REFOUT(1'b0), .XOROUT(64'h0), .RESIDUE(64'h0)) u_crc8 (
        .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_valid(v_i[0]), .o_ready(rdy_o[0]),
        .i_data(d[7:0]), .i_last(lst), .o_valid(val_o[0]), .i_ready(rdy),
        .o_crc(crc8), .o_match(mat_o[0]));

    crc_stream #(.BITS(16), .POLY(64'h1021), .INIT(64'hFFFF), .DATA_W(8), .REFIN(1'b0),
                 .REFOUT(1'b0), .XOROUT(64'h0), .RESIDUE(64'h0)) u_crc16 (
        .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_valid(v_i[1]), .o_ready(rdy_o[1]),
        .i_data(d[7:0]), .i_last(lst), .o_valid(val_o[1]), .i_ready(rdy),
        .o_crc(crc16), .o_match(mat_o[1]));

    crc_stream #(.BITS(32), .POLY(64'h04C11DB7), .INIT(64'hFFFFFFFF), .DATA_W(8), .REFIN(1'b1),
                 .REFOUT(1'b1), .XOROUT(64'hFFFFFFFF), .RESIDUE(64'h0)) u_crc32a (
        .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_valid(v_i[2]), .o_ready(rdy_o[2]),
        .i_data(d[7:0]), .i_last(lst), .o_valid(val_o[2]), .i_ready(rdy),
        .o_crc(crc32a), .o_match(mat_o[2]));

    crc_stream #(.BITS(32), .POLY(64'h04C11DB7), .INIT(64'hFFFFFFFF), .DATA_W(32), .REFIN(1'b1),
                 .REFOUT(1'b1), .XOROUT(64'hFFFFFFFF), .RESIDUE(64'h0)) u_crc32b (
        .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_valid(v_i[3]), .o_ready(rdy_o[3]),
        .i_data(d[31:0]), .i_last(lst), .o_valid(val_o[3]), .i_ready(rdy),
        .o_crc(crc32b), .o_match(mat_o[3]));

    crc_stream #(.BITS(5), .POLY(64'h15), .INIT(64'h1F), .DATA_W(3), .REFIN(1'b1),
                 .REFOUT(1'b1), .XOROUT(64'h0A), .RESIDUE(64'h05)) u_crc5 (
        .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_valid(v_i[4]), .o_ready(rdy_o[4]),
        .i_data(d[2:0]), .i_last(lst), .o_valid(val_o[4]), .i_ready(rdy),
        .o_crc(crc5), .o_match(mat_o[4]));

    function automatic cfg_t cfg_of(int k);
        cfg_t c;
        case (k)
            0:       c = '{8,  64'h07,       64'h0,        8,  1'b0, 1'b0, 64'h0,        64'h0};
            1:       c = '{16, 64'h1021,     64'hFFFF,     8,  1'b0, 1'b0, 64'h0,        64'h0};
            2:       c = '{32, 64'h04C11DB7, 64'hFFFFFFFF, 8,  1'b1, 1'b1, 64'hFFFFFFFF, 64'h0};
            3:       c = '{32, 64'h04C11DB7, 64'hFFFFFFFF, 32, 1'b1, 1'b1, 64'hFFFFFFFF, 64'h0};
            default: c = '{5,  64'h15,       64'h1F,       3,  1'b1, 1'b1, 64'h0A,       64'h05};
        endcase
        return c;
    endfunction

    // Raw register = (INIT * x^L + M(x) * x^BITS) mod G(x), done as long division
    // over the serialised message with INIT folded into its leading bits.
    function automatic logic [63:0] model_raw(cfg_t c, beat_q_t beats);
        bit          p[$];
        logic [63:0] r;
        foreach (beats[b])
            for (int j = 0; j < c.data_w; j++)
                p.push_back(c.refin ? beats[b][j] : beats[b][c.data_w-1-j]);
        for (int i = 0; i < c.bits; i++) p.push_back(1'b0);
        for (int i = 0; i < c.bits; i++) p[i] = p[i] ^ c.init[c.bits-1-i];
        for (int i = 0; i < p.size() - c.bits; i++) begin
            if (p[i]) begin
                p[i] = 1'b0;
                for (int j = 1; j <= c.bits; j++) p[i+j] = p[i+j] ^ c.poly[c.bits-j];
            end
        end
        r = '0;
        for (int i = 0; i < c.bits; i++) r[c.bits-1-i] = p[p.size()-c.bits+i];
        return r;
    endfunction

    function automatic logic [63:0] model_out(cfg_t c, logic [63:0] raw);
        logic [63:0] v;
        v = raw;
        if (c.refout) begin
            v = '0;
            for (int i = 0; i < c.bits; i++) v[i] = raw[c.bits-1-i];
        end
        return v ^ c.xorout;
    endfunction

    function automatic beat_q_t str_beats(string s, int extra);
        beat_q_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(64'(s[i]));
        if (extra >= 0) q.push_back(64'(extra));
        return q;
    endfunction

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic send_beat(int k, logic [63:0] data, bit last);
        int n = 0;
        @(negedge clk);
        sel = k; d = data; lst = last; vld = 1'b1;
        while (rdy_o[k] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: o_ready stayed low on instance %0d", k);
            vld = 1'b0; lst = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            vld = 1'b0; lst = 1'b0;
        end
    endtask

    // Sends a frame; result sampled just after the edge that took the last beat.
    task automatic run_frame(int k, beat_q_t beats, output logic [63:0] crc, output logic match);
        for (int i = 0; i < beats.size(); i++) send_beat(k, beats[i], i == beats.size() - 1);
        check($sformatf("valid_after_last[%0d]", k), 64'(val_o[k]), 64'd1);
        check($sformatf("ready_in_out[%0d]", k), 64'(rdy_o[k]), 64'd0);
        crc   = crc_o[k];
        match = mat_o[k];
        if (rdy) begin
            @(posedge clk);
            #1;
            check($sformatf("valid_dropped[%0d]", k), 64'(val_o[k]), 64'd0);
            check($sformatf("ready_back[%0d]", k), 64'(rdy_o[k]), 64'd1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt[7];
        logic [63:0] c;
        logic        m;
        cfg_t        cf;
        beat_q_t     q;

        rst = 1'b1; clr = 1'b0; vld = 1'b0; lst = 1'b0; rdy = 1'b1; sel = 0; d = '0;

        vt[0] = '{0, "123456789", -1,    64'hF4,       1'b0};
        vt[1] = '{1, "123456789", -1,    64'h29B1,     1'b0};
        vt[2] = '{2, "123456789", -1,    64'hCBF43926, 1'b0};
        vt[3] = '{0, "123456789", 'hF4,  64'h00,       1'b1};
        vt[4] = '{0, "123456789", 'hF5,  64'h07,       1'b0};
        vt[5] = '{0, "1",         -1,    64'h97,       1'b0};
        vt[6] = '{0, "",          0,     64'h00,       1'b1};

        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("rst_ready[%0d]", k), 64'(rdy_o[k]), 64'd1);
            check($sformatf("rst_valid[%0d]", k), 64'(val_o[k]), 64'd0);
            check($sformatf("rst_crc[%0d]", k), crc_o[k], 64'd0);
            check($sformatf("rst_match[%0d]", k), 64'(mat_o[k]), 64'd0);
        end
        rst = 1'b0;

        foreach (vt[i]) begin
            run_frame(vt[i].inst, str_beats(vt[i].msg, vt[i].extra), c, m);
            check($sformatf("vec%0d_crc", i), c, vt[i].exp_crc);
            check($sformatf("vec%0d_match", i), 64'(m), 64'(vt[i].exp_match));
        end

        // Word-wide and byte-wide CRC-32 over the same eight bytes.
        q = '{64'h34333231, 64'h38373635};
        run_frame(3, q, c, m);
        check("crc32_word", c, model_out(cfg_of(3), model_raw(cfg_of(3), q)));
        q = str_beats("12345678", -1);
        run_frame(2, q, c, m);
        check("crc32_byte8", c, model_out(cfg_of(2), model_raw(cfg_of(2), q)));

        // Backpressure: result held, extra beats ignored while OUT.
        rdy = 1'b0;
        run_frame(0, str_beats("123456789", -1), c, m);
        check("bp_first_crc", c, 64'hF4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sel = 0; d = 64'hA5; lst = 1'b1; vld = 1'b1;
            check("bp_valid", 64'(val_o[0]), 64'd1);
            check("bp_ready", 64'(rdy_o[0]), 64'd0);
            check("bp_crc", crc_o[0], 64'hF4);
            check("bp_match", 64'(mat_o[0]), 64'd0);
            @(posedge clk);
        end
        @(negedge clk);
        vld = 1'b0; lst = 1'b0; rdy = 1'b1;
        @(posedge clk);
        #1;
        check("bp_released", 64'(val_o[0]), 64'd0);
        run_frame(0, str_beats("123456789", -1), c, m);
        check("bp_second_crc", c, 64'hF4);

        // i_clr mid-frame, with a last beat offered in the same cycle.
        q = str_beats("1234", -1);
        foreach (q[i]) send_beat(0, q[i], 1'b0);
        @(negedge clk);
        clr = 1'b1; sel = 0; d = 64'h39; lst = 1'b1; vld = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0; vld = 1'b0; lst = 1'b0;
        check("clr_beat_dropped", 64'(val_o[0]), 64'd0);
        run_frame(0, str_beats("123456789", -1), c, m);
        check("clr_mid_crc", c, 64'hF4);

        // i_clr while holding a result.
        rdy = 1'b0;
        run_frame(0, str_beats("1", -1), c, m);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check("clr_out_valid", 64'(val_o[0]), 64'd0);
        check("clr_out_ready", 64'(rdy_o[0]), 64'd1);
        check("clr_out_crc_hold", crc_o[0], 64'h97);
        rdy = 1'b1;

        // i_rst mid-frame.
        q = str_beats("123", -1);
        foreach (q[i]) send_beat(0, q[i], 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid_ready", 64'(rdy_o[0]), 64'd1);
        check("rst_mid_valid", 64'(val_o[0]), 64'd0);
        check("rst_mid_crc", crc_o[0], 64'd0);
        check("rst_mid_match", 64'(mat_o[0]), 64'd0);
        run_frame(0, str_beats("123456789", -1), c, m);
        check("rst_mid_next_crc", c, 64'hF4);

        // Random frames against the reference model.
        for (int it = 0; it < 60; it++) begin
            int k;
            int len;
            k   = $urandom_range(0, 4);
            cf  = cfg_of(k);
            len = $urandom_range(1, 6);
            q.delete();
            for (int i = 0; i < len; i++)
                q.push_back({$urandom, $urandom} & ((64'd1 << cf.data_w) - 64'd1));
            rdy = ($urandom_range(0, 3) != 0);
            run_frame(k, q, c, m);
            check($sformatf("rnd%0d_crc[%0d]", it, k), c, model_out(cf, model_raw(cf, q)));
            check($sformatf("rnd%0d_match[%0d]", it, k), 64'(m),
                  64'(model_raw(cf, q) == cf.residue));
            if (!rdy) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                @(negedge clk);
                rdy = 1'b1;
                @(posedge clk);
                #1;
                check($sformatf("rnd%0d_drain[%0d]", it, k), 64'(val_o[k]), 64'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
